// File: rtl/alu_divider_pkg.sv
// Shared types for the iterative divider: FSM state encoding and per-operation flags.
package alu_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  // Sign/exception information captured at load and consumed in FIX.
  typedef struct packed {
    logic q_neg;
    logic r_neg;
    logic div_zero;
  } div_flags_t;

endpackage

// File: rtl/alu_divider_cla.sv
// Carry-lookahead adder (4-bit lookahead groups); the divider uses it as a trial subtractor.
// WIDTH must be a multiple of 4.
module alu_divider_cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    logic [4:0] w_c;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch);
    // w_c is a block-local temporary, so blocking updates chain correctly from group to group.
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int k = 0; k < WIDTH; k += 4) begin
      w_c[1] = w_g[k] | (w_p[k] & w_c[0]);
      w_c[2] = w_g[k+1] | (w_p[k+1] & w_g[k]) | (&w_p[k+1 -: 2] & w_c[0]);
      w_c[3] = w_g[k+2] | (w_p[k+2] & w_g[k+1]) | (&w_p[k+2 -: 2] & w_g[k])
             | (&w_p[k+2 -: 3] & w_c[0]);
      w_c[4] = w_g[k+3] | (w_p[k+3] & w_g[k+2]) | (&w_p[k+3 -: 2] & w_g[k+1])
             | (&w_p[k+3 -: 3] & w_g[k]) | (&w_p[k+3 -: 4] & w_c[0]);
      o_sum[k +: 4] = w_p[k +: 4] ^ w_c[3:0];
      w_c[0] = w_c[4];
    end
    o_cout = w_c[0];
  end

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned.
// Build option ALU_DIV_ZERO_FAST_EN: a zero divisor skips CALC and finishes in one cycle.
module alu_divider
  import alu_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       r_state;
  div_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_dvd_raw;
  div_flags_t       r_flags;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic             w_dsr_zero;
  logic [WIDTH-1:0] w_rem_shift;
  logic [WIDTH-1:0] w_trial;
  logic             w_cout;
  logic             w_nonneg;

  assign w_dvd_mag   = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dsr_mag   = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign w_dsr_zero  = (divisor == '0);
  assign w_rem_shift = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};

  // Trial subtract rem - divisor as rem + ~divisor + 1.
  alu_divider_cla #(
    .WIDTH(WIDTH)
  ) u_trial_sub (
    .i_a   (w_rem_shift),
    .i_b   (~r_div),
    .i_cin (1'b1),
    .o_sum (w_trial),
    .o_cout(w_cout)
  );

  // The bit shifted out of rem is the (WIDTH+1)th bit of the subtract: if set, the trial is non-negative.
  assign w_nonneg = w_cout | r_rem[WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (start) begin
`ifdef ALU_DIV_ZERO_FAST_EN
          w_next = w_dsr_zero ? DIV_FIX : DIV_CALC;
`else
          w_next = DIV_CALC;
`endif
        end
      end
      DIV_CALC: if (r_cnt == LAST_CNT) w_next = DIV_FIX;
      DIV_FIX:  w_next = DIV_IDLE;
      default:  w_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_dvd_raw   <= '0;
      r_flags     <= '0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_quo     <= w_dvd_mag;
            r_div     <= w_dsr_mag;
            r_dvd_raw <= dividend;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_flags   <= '{q_neg:    sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]),
                           r_neg:    sign & dividend[WIDTH-1],
                           div_zero: w_dsr_zero};
          end
        end
        DIV_CALC: begin
          r_rem <= w_nonneg ? w_trial : w_rem_shift;
          r_quo <= {r_quo[WIDTH-2:0], w_nonneg};
          r_cnt <= r_cnt + 1'b1;
        end
        DIV_FIX: begin
          r_done <= 1'b1;
          if (r_flags.div_zero) begin
            // Divide by zero reports all-ones and hands back the dividend untouched.
            r_quotient  <= '1;
            r_remainder <= r_dvd_raw;
            r_div_zero  <= 1'b1;
          end else begin
            r_quotient  <= r_flags.q_neg ? -r_quo : r_quo;
            r_remainder <= r_flags.r_neg ? -r_rem : r_rem;
            r_div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != DIV_IDLE);
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_alu_divider.sv
// Directed bench for alu_divider: vector table run back-to-back plus ignored-start and reset sequences.
module tb_alu_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

`ifdef ALU_DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  alu_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign     (sign),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one operation and waits for done; poke_k >= 0 pulses a stray start k cycles after acceptance.
  // Returns inside the done cycle so a following call issues its start back-to-back.
  task automatic do_op(input vec_t v, input string name, input int poke_k);
    int   k;
    int   busy_n;
    int   exp_lat;
    logic got;
    exp_lat = (FAST && v.b == 32'd0) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; sign = v.sgn; dividend = v.a; divisor = v.b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    k      = 0;
    busy_n = busy ? 1 : 0;
    got    = 1'b0;
    while (!got && k < 100) begin
      if (k == poke_k) begin
        start = 1'b1; sign = ~v.sgn; dividend = 32'd50; divisor = 32'd5;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      k++;
      if (done) begin
        got = 1'b1;
        check({name, " busy_with_done"}, {31'b0, busy}, 32'd0);
      end else if (busy) begin
        busy_n++;
      end
    end
    check({name, " latency"}, k, exp_lat);
    check({name, " busy_cycles"}, busy_n, exp_lat);
    check({name, " quotient"}, quotient, v.q);
    check({name, " remainder"}, remainder, v.r);
    check({name, " div_zero"}, {31'b0, div_zero}, {31'b0, v.dz});
  endtask

  initial begin
    int   n_done;
    vec_t v;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
    vecs[2]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
    vecs[3]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
    vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[6]  = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    vecs[7]  = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
    vecs[8]  = '{1'b1, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1};
    vecs[9]  = '{1'b0, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0};
    vecs[11] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0};
    vecs[12] = '{1'b1, 32'd7,          32'hFFFF_FF9C,  32'd0,          32'd7,          1'b0};

    rst = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",      {31'b0, busy},     32'd0);
    check("reset done",      {31'b0, done},     32'd0);
    check("reset quotient",  quotient,          32'd0);
    check("reset remainder", remainder,         32'd0);
    check("reset div_zero",  {31'b0, div_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Each operation starts in the previous one's done cycle.
    for (int i = 0; i < NV; i++) do_op(vecs[i], $sformatf("vec%0d", i), -1);

    @(posedge clk);
    #1;
    check("done one-cycle pulse", {31'b0, done}, 32'd0);
    check("result held",          remainder,     vecs[NV-1].r);

    v = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    do_op(v, "ignored_start", 10);

    @(negedge clk);
    start = 1'b1; sign = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midop reset busy",      {31'b0, busy},     32'd0);
    check("midop reset done",      {31'b0, done},     32'd0);
    check("midop reset quotient",  quotient,          32'd0);
    check("midop reset remainder", remainder,         32'd0);
    check("midop reset div_zero",  {31'b0, div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("no done after abort", n_done, 0);

    v = '{1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0};
    do_op(v, "post_reset", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
